// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: square or single-cycle pulse per channel.
// Latency: outputs are flops loaded from the next counter value, so tick/clk align with cnt_nxt == 0.
// Backpressure: none; channels free-run while enabled. New divisors wait for a wrap, sync or disable.
module clock_divider_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 120
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [N_CH-1:0]        en_in,
  input  logic [N_CH-1:0]        load_in,
  input  logic [N_CH*CNT_W-1:0]  div_in,
  input  logic [N_CH-1:0]        mode_in,
  input  logic                   sync_in,
  output logic [N_CH-1:0]        clk_out,
  output logic [N_CH-1:0]        tick_out,
  output logic [N_CH-1:0]        pend_out
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_RST = (DIV_RST == '0) ? '0 : DIV_RST - ONE;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pdiv;
    logic             mode;
    logic             pmode;
    logic             pend;
  } ch_t;

  // A divisor of zero runs exactly like a divisor of one.
  function automatic logic [CNT_W-1:0] period(input logic [CNT_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_t              st_q, st_d;
    logic             clk_q, tick_q, clk_d, tick_d;
    logic [CNT_W-1:0] p_cur, p_new, h_new, cnt_nxt, nd;
    logic             wrap, apply, nm;

    always_comb begin
      st_d    = st_q;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      cnt_nxt = '0;
      p_cur   = period(st_q.div);
      wrap    = (st_q.cnt == p_cur - ONE);
      apply   = !en_in[i] || sync_in || wrap;

      // A strobe coinciding with an apply point bypasses the pending registers.
      if (load_in[i]) begin
        nd = div_in[i*CNT_W +: CNT_W];
        nm = mode_in[i];
      end else if (st_q.pend) begin
        nd = st_q.pdiv;
        nm = st_q.pmode;
      end else begin
        nd = st_q.div;
        nm = st_q.mode;
      end

      if (apply) begin
        st_d.div  = nd;
        st_d.mode = nm;
        st_d.pend = 1'b0;
      end else if (load_in[i]) begin
        st_d.pdiv  = div_in[i*CNT_W +: CNT_W];
        st_d.pmode = mode_in[i];
        st_d.pend  = 1'b1;
      end

      p_new = period(st_d.div);
      h_new = (p_new >> 1) + CNT_W'(p_new[0]);

      // Parking at P-1 makes the first enabled edge a wrap, i.e. a full first period.
      if (!en_in[i]) begin
        st_d.cnt = p_new - ONE;
      end else begin
        cnt_nxt  = (sync_in || wrap) ? '0 : st_q.cnt + ONE;
        st_d.cnt = cnt_nxt;
        tick_d   = (cnt_nxt == '0);
        clk_d    = st_d.mode ? tick_d : (cnt_nxt < h_new);
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        st_q.div   <= DIV_RST;
        st_q.cnt   <= CNT_RST;
        st_q.pdiv  <= DIV_RST;
        st_q.mode  <= 1'b0;
        st_q.pmode <= 1'b0;
        st_q.pend  <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        st_q   <= st_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i]  = clk_q;
    assign tick_out[i] = tick_q;
    assign pend_out[i] = st_q.pend;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: defaults, pending/bypass loads, sync, disable, reset.
module tb_clock_divider_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       en, load, mode, clk_o, tick_o, pend_o;
  logic [N_CH*CNT_W-1:0] div;
  logic                  sync;

  int n_vec = 0;
  int n_err = 0;

  clock_divider_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_DEFAULT(120)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .en_in    (en),
    .load_in  (load),
    .div_in   (div),
    .mode_in  (mode),
    .sync_in  (sync),
    .clk_out  (clk_o),
    .tick_out (tick_o),
    .pend_out (pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_load(input int ch, input int d, input logic m);
    load[ch]              = 1'b1;
    div[ch*CNT_W +: CNT_W] = d[CNT_W-1:0];
    mode[ch]              = m;
  endtask

  initial begin
    rst = 1'b1; en = '1; load = '0; mode = '0; div = '0; sync = 1'b0;
    step(3);
    chk("rst_clk", clk_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_pend", pend_o, 0);

    // Default 120 period, first tick right after release
    rst = 1'b0;
    step(1);
    chk("first_clk", clk_o, 4'hF);
    chk("first_tick", tick_o, 4'hF);
    for (int k = 1; k < 120; k++) begin
      step(1);
      chk("def_clk", clk_o, (k < 60) ? 32'hF : 32'h0);
      chk("def_tick", tick_o, 0);
    end
    step(1);
    chk("def_wrap_tick", tick_o, 4'hF);
    chk("def_wrap_clk", clk_o, 4'hF);

    // Load D=4 on ch0 at cnt 10: current 120 period completes
    step(10);
    set_load(0, 4, 1'b0);
    step(1);
    load = '0;
    chk("pend_set", pend_o, 4'b0001);
    step(108);
    chk("pend_hold", pend_o, 4'b0001);
    chk("late_clk0", clk_o[0], 0);
    chk("late_tick0", tick_o[0], 0);
    step(1);
    chk("wrap4_tick", tick_o, 4'hF);
    chk("wrap4_pend", pend_o, 0);
    step(1); chk("p4_c1", clk_o[0], 1);
    step(1); chk("p4_c2", clk_o[0], 0);
    step(1); chk("p4_c3", clk_o[0], 0); chk("p4_t3", tick_o[0], 0);

    // Load in the wrap cycle bypasses pending: D=5 square at once
    set_load(0, 5, 1'b0);
    step(1);
    load = '0;
    chk("byp_pend", pend_o, 0);
    chk("byp_tick", tick_o[0], 1);
    chk("byp_clk", clk_o[0], 1);
    for (int k = 1; k < 5; k++) begin
      step(1);
      chk("p5_clk", clk_o[0], (k < 3) ? 32'h1 : 32'h0);
      chk("p5_pend", pend_o[0], 0);
    end
    step(1);
    chk("p5_wrap", tick_o[0], 1);

    // Two loads before the wrap: the last one (D=3) wins
    set_load(0, 9, 1'b0);
    step(1);
    set_load(0, 3, 1'b0);
    step(1);
    load = '0;
    chk("lw_pend", pend_o[0], 1);
    step(2);
    step(1);
    chk("lw_tick", tick_o[0], 1);
    chk("lw_pend_clr", pend_o[0], 0);
    step(2);
    chk("p3_notick", tick_o[0], 0);
    step(1);
    chk("p3_tick", tick_o[0], 1);

    // ch0 D=7, ch1 D=10 pending, then sync aligns every channel
    set_load(0, 7, 1'b0);
    set_load(1, 10, 1'b0);
    step(1);
    load = '0;
    chk("sy_pend", pend_o, 4'b0011);
    step(3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("sy_tick", tick_o, 4'hF);
    chk("sy_pend_clr", pend_o, 0);
    step(7);
    chk("sy_p7", tick_o, 4'b0001);
    step(3);
    chk("sy_p10", tick_o, 4'b0010);

    // Sync ignores a disabled channel
    en = 4'b0111;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("dis_sync_tick", tick_o, 4'b0111);
    chk("dis_sync_clk3", clk_o[3], 0);
    en = 4'hF;
    step(1);
    chk("reen_tick3", tick_o[3], 1);
    chk("reen_clk3", clk_o[3], 1);

    // ch2 D=0 pulse and ch3 D=1 square, applied by sync
    set_load(2, 0, 1'b1);
    set_load(3, 1, 1'b0);
    step(1);
    load = '0;
    chk("d01_pend", pend_o, 4'b1100);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("d01_clk", clk_o[3:2], 2'b11);
      chk("d01_tick", tick_o[3:2], 2'b11);
      step(1);
    end

    // Pending load then reset mid-period: discarded, D back to 120
    set_load(0, 4, 1'b0);
    step(1);
    load = '0;
    chk("rp_pend", pend_o[0], 1);
    rst = 1'b1;
    step(1);
    chk("rp_rst_pend", pend_o, 0);
    chk("rp_rst_clk", clk_o, 0);
    chk("rp_rst_tick", tick_o, 0);
    rst = 1'b0;
    step(1);
    chk("rp_first", tick_o, 4'hF);
    chk("rp_first_clk", clk_o, 4'hF);
    step(59);
    chk("rp_c59", clk_o, 4'hF);
    step(1);
    chk("rp_c60", clk_o, 0);
    step(59);
    chk("rp_c119", tick_o, 0);
    step(1);
    chk("rp_wrap", tick_o, 4'hF);

    // Disable 3 cycles with a pending ch1 load: applied at once, then a full first period
    set_load(1, 6, 1'b0);
    step(1);
    load = '0;
    chk("en_pend", pend_o, 4'b0010);
    en = '0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("en_off_clk", clk_o, 0);
      chk("en_off_tick", tick_o, 0);
      chk("en_off_pend", pend_o, 0);
    end
    en = '1;
    step(1);
    chk("en_on_tick", tick_o, 4'hF);
    chk("en_on_clk", clk_o, 4'hF);
    step(3);
    chk("en_p6_clk", clk_o[1], 0);
    step(2);
    chk("en_p6_notick", tick_o, 0);
    step(1);
    chk("en_p6_tick", tick_o, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent divider channels.
REQ-002 SHALL have parameter CNT_W, default 16: divisor and counter width per channel.
REQ-003 SHALL have parameter DIV_DEFAULT, default 120: divisor loaded at reset, giving 120 MHz to 1 MHz.
REQ-004 SHALL have port clk_in, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en_in, input, N_CH: per-channel run enable.
REQ-007 SHALL have port load_in, input, N_CH: per-channel one-cycle divisor/mode load strobe.
REQ-008 SHALL have port div_in, input, N_CH*CNT_W: divisor per channel, channel i at bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port mode_in, input, N_CH: per-channel mode, 0 = square (~50% duty), 1 = single-cycle pulse.
REQ-010 SHALL have port sync_in, input, 1: global phase restart of all enabled channels.
REQ-011 SHALL have port clk_out, output, N_CH: registered divided clock or pulse per channel.
REQ-012 SHALL have port tick_out, output, N_CH: registered one-cycle strobe at the start of each period.
REQ-013 SHALL have port pend_out, output, N_CH: 1 while a loaded divisor/mode awaits application.

Function
REQ-014 Each channel SHALL hold an active divisor D, active mode M, counter cnt, pending divisor/mode registers and a pending flag.
REQ-015 Effective period SHALL be P = max(D,1); divisor 0 SHALL behave exactly as 1.
REQ-016 When enabled, cnt_nxt SHALL be 0 if cnt == P-1, else cnt+1.
REQ-017 clk_out and tick_out SHALL be flops loaded from cnt_nxt; no combinational path from cnt to any output.
REQ-018 tick_out SHALL be loaded with (cnt_nxt == 0) when enabled.
REQ-019 In square mode, clk_out SHALL be loaded with (cnt_nxt < H), H = (P>>1) + P[0]: high ceil(P/2) cycles, low floor(P/2) cycles; P = 1 gives constant 1.
REQ-020 In pulse mode, clk_out SHALL equal tick_out.
REQ-021 A load_in strobe SHALL capture div_in slice and mode_in bit into pending registers and set pend_out on the next cycle.
REQ-022 A second load before application SHALL overwrite the pending registers; the last load wins.
REQ-023 Pending values SHALL become active at the wrap edge (cnt == P-1, enabled) and pend_out SHALL clear on that edge; the new period starts from cnt_nxt = 0.
REQ-024 A load strobe in the wrap cycle itself SHALL bypass the pending registers: the new values become active on that edge and pend_out stays 0.
REQ-025 en_in = 0 SHALL force cnt to P-1, both outputs to 0, and apply any pending values immediately.
REQ-026 On the first enabled edge after en_in rises, cnt_nxt SHALL be 0, giving tick_out = 1 and a full first period.
REQ-027 sync_in = 1 SHALL force cnt_nxt = 0 on every enabled channel and apply pending values (load bypass included), so all enabled channels tick in the same cycle.
REQ-028 sync_in SHALL have no effect on disabled channels.
REQ-029 Precedence SHALL be rst_in > en_in = 0 > sync_in > normal count.
REQ-030 Channels SHALL be fully independent apart from the shared sync_in.

Reset
REQ-031 While rst_in = 1: D = DIV_DEFAULT, M = 0, cnt = max(DIV_DEFAULT,1)-1, pending flag 0, and clk_out, tick_out, pend_out = 0.
REQ-032 Reset mid-period SHALL discard pending loads, with no partial-period output afterwards.
REQ-033 The first edge with rst_in = 0 and en_in = 1 SHALL give clk_out = 1 and tick_out = 1.

Verification
REQ-034 Reset, en = all 1, defaults -> each clk_out is 1 for 60 cycles, 0 for 60 cycles; tick_out every 120 cycles; first tick in the first cycle after reset release.
REQ-035 Load D = 5, square, on ch0 -> after the next wrap, pattern 1,1,1,0,0 repeating; pend_out high from the load until the wrap.
REQ-036 Load D = 4 at cnt = 10 of a 120 period -> current period completes all 120 cycles, then period 4; a load in the wrap cycle gives period 4 immediately with pend_out never set.
REQ-037 ch0 D = 7, ch1 D = 10 at arbitrary phases, pulse sync_in -> both tick_out in the next cycle and periods restart aligned.
REQ-038 D = 0 in pulse mode -> tick_out and clk_out constant 1; D = 1 in square mode -> clk_out constant 1.
REQ-039 Pending load, then rst_in mid-period -> pend_out = 0 and D = 120 after reset; en_in low for 3 cycles -> outputs 0, then a fresh full period.
